// File: rtl/parity_scan_sequencer.sv
// parity_scan_sequencer: two-stage valid/ready pipeline producing the inclusive
// running XOR prefix of each WIDTH-bit beat, with the prefix carried across the
// beats of a segment.
// Build option: define PARITY_SCAN_CARRY_EN to build the cross-beat carry;
// without it every beat is scanned independently.

module GenericPrefixXor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_prefix
);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    // Log-depth network: level s folds in the partial prefix 2^s bits below,
    // which for XOR is simply v ^ (v << 2^s).
    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;
        if (s == 0) begin : g_first
            assign w_in = i_data;
        end else begin : g_next
            assign w_in = g_lvl[s-1].w_out;
        end
        assign w_out = w_in ^ (w_in << (1 << s));
    end

    assign o_prefix = g_lvl[LEVELS-1].w_out;
endmodule

module parity_scan_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             iw_clk,
    input  logic             iw_rst_n,
    input  logic             iw_valid,
    output logic             ow_ready,
    input  logic [WIDTH-1:0] iwv_data,
    input  logic             iw_last,
    output logic             ow_valid,
    input  logic             iw_ready,
    output logic [WIDTH-1:0] owv_data,
    output logic             ow_last,
    output logic             ow_parity,
    output logic [CNT_W-1:0] owv_beat
);
    logic             r_s1_full;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_last;
    logic             r_s2_full;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_last;
    logic [CNT_W-1:0] r_s2_beat;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_adv;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_local;
    logic [WIDTH-1:0] w_scan;

    GenericPrefixXor #(.WIDTH(WIDTH)) u_prefix (
        .i_data   (r_s1_data),
        .o_prefix (w_local)
    );

    assign w_s1_adv  = r_s1_full && (!r_s2_full || iw_ready);
    assign ow_ready  = !r_s1_full || w_s1_adv;
    assign w_in_xfer = iw_valid && ow_ready;

`ifdef PARITY_SCAN_CARRY_EN
    logic r_carry;

    assign w_scan = w_local ^ {WIDTH{r_carry}};

    // Segment carry: follows the beat moving S1->S2, cleared at segment end
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_carry <= 1'b0;
        end else if (w_s1_adv) begin
            r_carry <= r_s1_last ? 1'b0 : w_scan[WIDTH-1];
        end
    end
`else
    assign w_scan = w_local;
`endif

    // Stage S1: capture the incoming beat, empty when it moves on
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_s1_full <= 1'b0;
            r_s1_data <= '0;
            r_s1_last <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_full <= 1'b1;
            r_s1_data <= iwv_data;
            r_s1_last <= iw_last;
        end else if (w_s1_adv) begin
            r_s1_full <= 1'b0;
        end
    end

    // Stage S2: output register, holds under stall, empties on output transfer
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_s2_full <= 1'b0;
            r_s2_data <= '0;
            r_s2_last <= 1'b0;
            r_s2_beat <= '0;
        end else if (w_s1_adv) begin
            r_s2_full <= 1'b1;
            r_s2_data <= w_scan;
            r_s2_last <= r_s1_last;
            r_s2_beat <= r_cnt;
        end else if (r_s2_full && iw_ready) begin
            r_s2_full <= 1'b0;
        end
    end

    // Beat index within the segment, wraps freely
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_cnt <= '0;
        end else if (w_s1_adv) begin
            r_cnt <= r_s1_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign ow_valid  = r_s2_full;
    assign owv_data  = r_s2_data;
    assign ow_last   = r_s2_last;
    assign ow_parity = r_s2_data[WIDTH-1];
    assign owv_beat  = r_s2_beat;
endmodule
